// File: rtl/voice_allocator_pkg.sv
// Shared encodings and helpers for the four-voice allocator.
// Voice-state values are fixed so they match the wave generator's view of a voice.
package voice_allocator_pkg;

   localparam int NUM_VOICES_DEF = 4;
   localparam int INCR_W         = 24;
   localparam int NOTE_W         = 7;

   typedef enum logic [1:0] {
      V_IDLE      = 2'd0,
      V_ACTIVE    = 2'd1,
      V_RELEASING = 2'd2
   } voice_state_e;

   typedef enum logic [1:0] {
      FSM_READY = 2'd0,
      FSM_STEAL = 2'd1,
      FSM_PANIC = 2'd2
   } ctrl_state_e;

   function automatic logic is_busy(input voice_state_e s);
      return (s != V_IDLE);
   endfunction

endpackage

// File: rtl/voice_allocator_prio_pick4.sv
// Lowest-index one-hot picker over a 4-bit candidate mask, with a found flag.
module prio_pick4 (
   input  logic [3:0] i_mask,
   output logic [3:0] o_onehot,
   output logic       o_found
);

   // Two's-complement trick isolates the lowest set bit.
   assign o_onehot = i_mask & (~i_mask + 4'd1);
   assign o_found  = |i_mask;

endmodule

// File: rtl/voice_allocator.sv
// Schedules note-on/note-off requests onto four voices: free-voice pick, retrigger,
// steal (releasing first, then round-robin), release, finish and panic handling.
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_on,
   input  logic [NOTE_W-1:0]            req_note,
   input  logic [INCR_W-1:0]            req_increment,
   input  logic                         panic,
   input  logic [NUM_VOICES-1:0]        note_finished,
   output logic [INCR_W*NUM_VOICES-1:0] increment,
   output logic [NUM_VOICES-1:0]        note_start,
   output logic [NUM_VOICES-1:0]        note_release,
   output logic [NUM_VOICES-1:0]        note_reset,
   output logic [NUM_VOICES-1:0]        voice_busy,
   output logic                         req_dropped
);

   ctrl_state_e          r_fsm, w_fsm_nxt;
   voice_state_e         r_vstate     [NUM_VOICES];
   voice_state_e         w_vstate_nxt [NUM_VOICES];
   logic [NOTE_W-1:0]    r_note       [NUM_VOICES];
   logic [INCR_W-1:0]    r_incr       [NUM_VOICES];
   logic [1:0]           r_sp, w_sp_nxt;
   logic [3:0]           r_steal_oh, w_steal_oh_nxt;
   logic [NOTE_W-1:0]    r_steal_note;
   logic [INCR_W-1:0]    r_steal_incr;

   logic                 r_req_ready;
   logic [3:0]           r_note_start, r_note_release, r_note_reset, r_voice_busy;
   logic                 r_req_dropped;

   logic                 w_accept;
   logic [3:0]           w_idle_mask, w_rel_mask, w_match_mask, w_busy_cur;
   logic [3:0]           w_idle_oh, w_rel_oh, w_match_oh;
   logic                 w_idle_found, w_rel_found, w_match_found;
   logic [3:0]           w_start, w_release, w_reset, w_victim;
   logic                 w_dropped, w_do_steal, w_capture;
   logic [NOTE_W-1:0]    w_load_note;
   logic [INCR_W-1:0]    w_load_incr;

   assign w_accept = req_valid & r_req_ready & ~panic;

   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         w_idle_mask[v]  = (r_vstate[v] == V_IDLE);
         w_rel_mask[v]   = (r_vstate[v] == V_RELEASING);
         w_match_mask[v] = (r_vstate[v] == V_ACTIVE) && (r_note[v] == req_note);
         w_busy_cur[v]   = is_busy(r_vstate[v]);
      end
   end

   prio_pick4 u_pick_idle  (.i_mask(w_idle_mask),  .o_onehot(w_idle_oh),  .o_found(w_idle_found));
   prio_pick4 u_pick_rel   (.i_mask(w_rel_mask),   .o_onehot(w_rel_oh),   .o_found(w_rel_found));
   prio_pick4 u_pick_match (.i_mask(w_match_mask), .o_onehot(w_match_oh), .o_found(w_match_found));

   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      w_fsm_nxt      = r_fsm;
      w_sp_nxt       = r_sp;
      w_steal_oh_nxt = r_steal_oh;
      w_capture      = 1'b0;
      w_start        = '0;
      w_release      = '0;
      w_reset        = '0;
      w_victim       = '0;
      w_do_steal     = 1'b0;
      w_dropped      = 1'b0;
      w_load_note    = req_note;
      w_load_incr    = req_increment;
      for (int v = 0; v < NUM_VOICES; v++)
         w_vstate_nxt[v] = (note_finished[v] && is_busy(r_vstate[v])) ? V_IDLE : r_vstate[v];

      if (panic) begin
         w_fsm_nxt = FSM_PANIC;
         w_sp_nxt  = 2'd0;
         if (r_fsm != FSM_PANIC)
            w_reset = w_busy_cur;
         for (int v = 0; v < NUM_VOICES; v++)
            w_vstate_nxt[v] = V_IDLE;
      end else begin
         case (r_fsm)
            FSM_READY: begin
               if (w_accept) begin
                  if (req_on) begin
                     if (w_match_found) begin
                        w_victim   = w_match_oh;
                        w_do_steal = 1'b1;
                     end else if (w_idle_found) begin
                        w_start = w_idle_oh;
                     end else if (w_rel_found) begin
                        w_victim   = w_rel_oh;
                        w_do_steal = 1'b1;
                     end else begin
                        w_victim   = 4'b0001 << r_sp;
                        w_do_steal = 1'b1;
                        w_sp_nxt   = r_sp + 2'd1;
                     end
                  end else if (w_match_found) begin
                     w_release = w_match_oh;
                  end else begin
                     w_dropped = 1'b1;
                  end
               end
            end
            FSM_STEAL: begin
               w_start     = r_steal_oh;
               w_load_note = r_steal_note;
               w_load_incr = r_steal_incr;
               w_fsm_nxt   = FSM_READY;
            end
            default: w_fsm_nxt = FSM_READY;
         endcase

         if (w_do_steal) begin
            w_reset        = w_victim;
            w_steal_oh_nxt = w_victim;
            w_capture      = 1'b1;
            w_fsm_nxt      = FSM_STEAL;
         end

         // A start overrides a finish reported for the same voice in the same cycle.
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_release[v]) w_vstate_nxt[v] = V_RELEASING;
            if (w_start[v])   w_vstate_nxt[v] = V_ACTIVE;
         end
      end
   end

   // NOTE: the per-voice note/increment arrays are reset too, since increment must read 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm          <= FSM_READY;
         r_sp           <= 2'd0;
         r_steal_oh     <= '0;
         r_steal_note   <= '0;
         r_steal_incr   <= '0;
         r_req_ready    <= 1'b0;
         r_note_start   <= '0;
         r_note_release <= '0;
         r_note_reset   <= '0;
         r_voice_busy   <= '0;
         r_req_dropped  <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_vstate[v] <= V_IDLE;
            r_note[v]   <= '0;
            r_incr[v]   <= '0;
         end
      end else begin
         r_fsm          <= w_fsm_nxt;
         r_sp           <= w_sp_nxt;
         r_steal_oh     <= w_steal_oh_nxt;
         r_req_ready    <= (w_fsm_nxt == FSM_READY) && !panic;
         r_note_start   <= w_start;
         r_note_release <= w_release;
         r_note_reset   <= w_reset;
         r_req_dropped  <= w_dropped;
         if (w_capture) begin
            r_steal_note <= req_note;
            r_steal_incr <= req_increment;
         end
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_vstate[v]     <= w_vstate_nxt[v];
            r_voice_busy[v] <= is_busy(w_vstate_nxt[v]);
            if (w_start[v]) begin
               r_incr[v] <= w_load_incr;
               r_note[v] <= w_load_note;
            end
         end
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++)
         increment[INCR_W*v +: INCR_W] = r_incr[v];
   end

   assign req_ready    = r_req_ready;
   assign note_start   = r_note_start;
   assign note_release = r_note_release;
   assign note_reset   = r_note_reset;
   assign voice_busy   = r_voice_busy;
   assign req_dropped  = r_req_dropped;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: a cycle-by-cycle vector table followed by
// hand-written panic-during-steal and asynchronous-reset sequences.
module tb_voice_allocator;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_on, panic;
   logic        req_ready, req_dropped;
   logic [6:0]  req_note;
   logic [23:0] req_increment;
   logic [3:0]  note_finished, note_start, note_release, note_reset, voice_busy;
   logic [95:0] increment;

   int n_tests = 0;
   int n_fail  = 0;

   voice_allocator #(.NUM_VOICES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_on(req_on),
      .req_note(req_note), .req_increment(req_increment),
      .panic(panic), .note_finished(note_finished),
      .increment(increment), .note_start(note_start), .note_release(note_release),
      .note_reset(note_reset), .voice_busy(voice_busy), .req_dropped(req_dropped)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   typedef struct {
      logic        v, on;
      logic [6:0]  note;
      logic [23:0] incr;
      logic        pan;
      logic [3:0]  fin;
      logic        rdy;
      logic [3:0]  start, rel, rst_p, busy;
      logic        drop;
      int          iv;
      logic [23:0] ival;
   } vec_t;

   function automatic vec_t mk(input logic v, on, input logic [6:0] note, input logic [23:0] incr,
                               input logic [3:0] fin, input logic rdy,
                               input logic [3:0] start, rel, rst_p, busy, input logic drop,
                               input int iv, input logic [23:0] ival);
      vec_t r;
      r.v = v; r.on = on; r.note = note; r.incr = incr; r.pan = 1'b0; r.fin = fin;
      r.rdy = rdy; r.start = start; r.rel = rel; r.rst_p = rst_p; r.busy = busy;
      r.drop = drop; r.iv = iv; r.ival = ival;
      return r;
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, on, input logic [6:0] note, input logic [23:0] incr,
                        input logic pan, input logic [3:0] fin);
      req_valid = v; req_on = on; req_note = note; req_increment = incr;
      panic = pan; note_finished = fin;
   endtask

   // Inputs are applied at a falling edge; outputs are compared at the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_outs(input string tag, input logic rdy, input logic [3:0] start, rel,
                             rst_p, busy, input logic drop);
      check({tag, " req_ready"},    96'(req_ready),    96'(rdy));
      check({tag, " note_start"},   96'(note_start),   96'(start));
      check({tag, " note_release"}, 96'(note_release), 96'(rel));
      check({tag, " note_reset"},   96'(note_reset),   96'(rst_p));
      check({tag, " voice_busy"},   96'(voice_busy),   96'(busy));
      check({tag, " req_dropped"},  96'(req_dropped),  96'(drop));
   endtask

   vec_t tbl [26];

   initial begin
      //            v  on note  incr      fin      rdy start    rel      reset    busy     drp iv ival
      tbl[0]  = mk(1, 1, 7'd60, 24'h1000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0, 24'h1000);
      tbl[1]  = mk(1, 1, 7'd61, 24'h2000, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 0, 1, 24'h2000);
      tbl[2]  = mk(1, 1, 7'd62, 24'h3000, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0111, 0, 2, 24'h3000);
      tbl[3]  = mk(1, 1, 7'd63, 24'h4000, 4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 4'b1111, 0, 3, 24'h4000);
      tbl[4]  = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0, 24'h1000);
      // Round-robin steals: voice 0, then voice 1.
      tbl[5]  = mk(1, 1, 7'd64, 24'h5000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0001, 4'b1111, 0, 0, 24'h1000);
      tbl[6]  = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 0, 0, 24'h5000);
      tbl[7]  = mk(1, 1, 7'd65, 24'h6000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0010, 4'b1111, 0, 1, 24'h2000);
      tbl[8]  = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 0, 1, 24'h6000);
      // Release voice 1, finish it three cycles later, reuse it without a reset.
      tbl[9]  = mk(1, 0, 7'd65, 24'h0,    4'b0000, 1, 4'b0000, 4'b0010, 4'b0000, 4'b1111, 0, 1, 24'h6000);
      tbl[10] = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1, 24'h6000);
      tbl[11] = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1, 24'h6000);
      tbl[12] = mk(0, 0, 7'd0,  24'h0,    4'b0010, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 0, 1, 24'h6000);
      tbl[13] = mk(1, 1, 7'd66, 24'h7000, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 0, 1, 24'h7000);
      // Dropped note-off.
      tbl[14] = mk(1, 0, 7'd99, 24'h0,    4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 1, 24'h7000);
      tbl[15] = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1, 24'h7000);
      // Retrigger of note 62 on voice 2; steal pointer untouched.
      tbl[16] = mk(1, 1, 7'd62, 24'h8000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0100, 4'b1111, 0, 2, 24'h3000);
      tbl[17] = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 0, 2, 24'h8000);
      // Releasing voice is preferred over round-robin.
      tbl[18] = mk(1, 0, 7'd63, 24'h0,    4'b0000, 1, 4'b0000, 4'b1000, 4'b0000, 4'b1111, 0, 3, 24'h4000);
      tbl[19] = mk(1, 1, 7'd67, 24'h9000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1000, 4'b1111, 0, 3, 24'h4000);
      tbl[20] = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 4'b1111, 0, 3, 24'h9000);
      // Round-robin resumes at voice 2.
      tbl[21] = mk(1, 1, 7'd68, 24'hA000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0100, 4'b1111, 0, 2, 24'h8000);
      tbl[22] = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 0, 2, 24'hA000);
      // Finish of voice 2 on the accept edge: still a steal (voice 3), voice 2 freed.
      tbl[23] = mk(1, 1, 7'd69, 24'hB000, 4'b0100, 0, 4'b0000, 4'b0000, 4'b1000, 4'b1011, 0, 3, 24'h9000);
      tbl[24] = mk(0, 0, 7'd0,  24'h0,    4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 4'b1011, 0, 3, 24'hB000);
      tbl[25] = mk(1, 1, 7'd70, 24'hC000, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 0, 2, 24'hC000);

      drive(0, 0, 7'd0, 24'h0, 0, 4'b0000);
      rst = 1'b1;
      @(negedge clk);
      check_outs("reset", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      check("reset increment", increment, 96'h0);
      rst = 1'b0;
      step();
      check("post-reset req_ready", 96'(req_ready), 96'd1);

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].v, tbl[i].on, tbl[i].note, tbl[i].incr, tbl[i].pan, tbl[i].fin);
         step();
         check_outs($sformatf("row%0d", i), tbl[i].rdy, tbl[i].start, tbl[i].rel,
                    tbl[i].rst_p, tbl[i].busy, tbl[i].drop);
         check($sformatf("row%0d increment[v%0d]", i, tbl[i].iv),
               96'(increment[tbl[i].iv*24 +: 24]), 96'(tbl[i].ival));
      end

      // Panic during STEAL: steal of voice 0 (pointer at 0) is abandoned.
      drive(1, 1, 7'd71, 24'hD000, 0, 4'b0000);
      step();
      check_outs("steal-before-panic", 0, 4'b0000, 4'b0000, 4'b0001, 4'b1111, 0);
      drive(0, 0, 7'd0, 24'h0, 1, 4'b0000);
      step();
      check_outs("panic-entry", 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(1, 1, 7'd72, 24'hE000, 1, 4'b0000);
      step();
      check_outs("panic-hold", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      drive(0, 0, 7'd0, 24'h0, 0, 4'b0000);
      step();
      check_outs("panic-exit", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      check("panic increment v0 kept", 96'(increment[23:0]), 96'h5000);

      // Steal pointer back at 0: refill, then the next steal hits voice 0.
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 7'(i + 1), 24'(i + 1), 0, 4'b0000);
         step();
         check($sformatf("refill%0d note_start", i), 96'(note_start), 96'(4'b0001 << i));
      end
      drive(1, 1, 7'd5, 24'h55, 0, 4'b0000);
      step();
      check_outs("sp-after-panic", 0, 4'b0000, 4'b0000, 4'b0001, 4'b1111, 0);

      // Asynchronous reset in the middle of the STEAL cycle.
      drive(0, 0, 7'd0, 24'h0, 0, 4'b0000);
      #2 rst = 1'b1;
      #1;
      check_outs("async-rst", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      check("async-rst increment", increment, 96'h0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_outs("after-async-rst", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
